gf2m_571_reducer: RTL and testbench

GF2M_571_REDUCER -- requirements
Module: gf2m_571_reducer

---
 rtl/gf2m_571_reducer.sv | 104 ++++++++++
 tb/tb_gf2m_571_reducer.sv | 188 ++++++++++++++++++
 2 files changed

// File: rtl/gf2m_571_reducer.sv
// GF(2^571) reducer for the NIST B-571 trinomial-free pentanomial
// f(x) = x^571 + x^10 + x^5 + x^2 + 1.
// Takes an unreduced 1142-bit carry-less product and folds it down to a
// 571-bit field element in two XOR-only passes, with a fixed 4-cycle cadence.
module gf2m_571_reducer (
  input  logic          clk,
  input  logic          rst,
  input  logic          start,
  input  logic [1141:0] c_in,
  output logic [570:0]  r,
  output logic          busy,
  output logic          done
);

  typedef enum logic [1:0] {
    IDLE,
    FOLD1,
    FOLD2,
    OUT
  } state_t;

  state_t         state;
  state_t         state_next;
  logic [1141:0]  acc;
  logic [570:0]   hi;
  logic [580:0]   fold1;
  logic [9:0]     hi2;
  logic [570:0]   fold2;

  // First fold: x^571 == x^10 + x^5 + x^2 + 1, so the upper half folds into
  // a 581-bit value (the <<10 term spills 10 bits past bit 570).
  always_comb begin
    hi    = acc[1141:571];
    fold1 = {10'b0, acc[570:0]}
          ^ {10'b0, hi}
          ^ ({10'b0, hi} << 2)
          ^ ({10'b0, hi} << 5)
          ^ ({10'b0, hi} << 10);
  end

  // Second fold: the 10 spill bits fold once more; the result cannot spill
  // again since hi2<<10 reaches at most bit 19.
  always_comb begin
    hi2   = acc[580:571];
    fold2 = acc[570:0]
          ^ {561'b0, hi2}
          ^ ({561'b0, hi2} << 2)
          ^ ({561'b0, hi2} << 5)
          ^ ({561'b0, hi2} << 10);
  end

  // State register.
  always_ff @(posedge clk) begin
    if (rst) begin
      state <= IDLE;
    end else begin
      state <= state_next;
    end
  end

  // Next-state logic; start is only honoured in IDLE.
  always_comb begin
    state_next = state;
    case (state)
      IDLE:    if (start) state_next = FOLD1;
      FOLD1:   state_next = FOLD2;
      FOLD2:   state_next = OUT;
      OUT:     state_next = IDLE;
      default: state_next = IDLE;
    endcase
  end

  // Datapath: accumulator folding, result register and status flags.
  // busy is registered from the next state so it tracks FOLD1..OUT exactly.
  always_ff @(posedge clk) begin
    if (rst) begin
      acc  <= '0;
      r    <= '0;
      busy <= 1'b0;
      done <= 1'b0;
    end else begin
      done <= 1'b0;
      busy <= (state_next != IDLE);
      case (state)
        IDLE: begin
          if (start) acc <= c_in;
        end
        FOLD1: begin
          acc <= {561'b0, fold1};
        end
        FOLD2: begin
          acc <= {571'b0, fold2};
        end
        OUT: begin
          r    <= acc[570:0];
          done <= 1'b1;
        end
        default: begin
        end
      endcase
    end
  end

endmodule

// File: tb/tb_gf2m_571_reducer.sv
// Directed and random checks for gf2m_571_reducer against a bit-serial
// long-division reference of polynomial mod f(x).
module tb_gf2m_571_reducer;

  logic          clk;
  logic          rst;
  logic          start;
  logic [1141:0] c_in;
  logic [570:0]  r;
  logic          busy;
  logic          done;

  int checks;
  int errors;

  gf2m_571_reducer dut (
    .clk   (clk),
    .rst   (rst),
    .start (start),
    .c_in  (c_in),
    .r     (r),
    .busy  (busy),
    .done  (done)
  );

  initial clk = 1'b0;
  always #5 clk = ~clk;

  // Reference: schoolbook long division, highest degree first.
  function automatic logic [570:0] ref_mod(input logic [1141:0] c);
    logic [1141:0] t;
    logic [1141:0] f;
    t = c;
    f = '0;
    f[571] = 1'b1;
    f[10]  = 1'b1;
    f[5]   = 1'b1;
    f[2]   = 1'b1;
    f[0]   = 1'b1;
    for (int i = 1141; i >= 571; i--) begin
      if (t[i]) t = t ^ (f << (i - 571));
    end
    return t[570:0];
  endfunction

  function automatic logic [1141:0] clmul(input logic [570:0] a, input logic [570:0] b);
    logic [1141:0] p;
    p = '0;
    for (int i = 0; i < 571; i++) begin
      if (b[i]) p = p ^ ({571'b0, a} << i);
    end
    return p;
  endfunction

  function automatic logic [1141:0] rand_wide();
    logic [1151:0] v;
    for (int w = 0; w < 36; w++) v[w*32 +: 32] = $urandom;
    return v[1141:0];
  endfunction

  task automatic chk(input string tag, input logic [570:0] obs, input logic [570:0] exp);
    checks++;
    assert (obs === exp)
      else begin
        errors++;
        $error("FAIL %s observed=%0h expected=%0h", tag, obs, exp);
      end
  endtask

  // Caller must be at a negedge. Pulses start for one edge, then waits
  // (bounded) for done and checks latency, result and busy.
  task automatic reduce(input logic [1141:0] c, input logic [570:0] exp, input string tag);
    int n;
    c_in  = c;
    start = 1'b1;
    @(negedge clk);
    start = 1'b0;
    c_in  = rand_wide();
    chk({tag, "_busy"}, {570'b0, busy}, 571'd1);
    n = 0;
    while (!done && n < 10) begin
      @(negedge clk);
      n++;
    end
    chk({tag, "_latency"}, 571'(n), 571'd3);
    chk({tag, "_r"}, r, exp);
    chk({tag, "_busy_done"}, {570'b0, busy}, 571'd0);
  endtask

  logic [570:0]  exp_v;
  logic [570:0]  r_hold;
  logic [1141:0] c_v;
  logic [1141:0] vec [6];
  logic [570:0]  seen [$];
  int            pulses;

  initial begin
    checks = 0;
    errors = 0;
    rst    = 1'b1;
    start  = 1'b0;
    c_in   = '0;
    repeat (2) @(negedge clk);
    chk("reset_r", r, '0);
    chk("reset_busy", {570'b0, busy}, 571'd0);
    chk("reset_done", {570'b0, done}, 571'd0);
    rst = 1'b0;

    // x^571 -> x^10 + x^5 + x^2 + 1
    c_v = '0; c_v[571] = 1'b1;
    reduce(c_v, 571'h425, "x571");
    @(negedge clk);
    chk("done_one_cycle", {570'b0, done}, 571'd0);

    // x^1141 -> x^570 + x^19 + x^4 + x^3 + x (needs second fold)
    c_v = '0; c_v[1141] = 1'b1;
    exp_v = '0; exp_v[570] = 1'b1; exp_v[19] = 1'b1; exp_v[4] = 1'b1;
    exp_v[3] = 1'b1; exp_v[1] = 1'b1;
    reduce(c_v, exp_v, "x1141");

    reduce(1142'h1234, 571'h1234, "small");
    reduce('0, '0, "zero");
    c_v = '0; c_v[570:0] = '1;
    reduce(c_v, '1, "low_all_ones");

    // r holds while idle with c_in toggling
    r_hold = r;
    for (int k = 0; k < 4; k++) begin
      c_in = rand_wide();
      @(negedge clk);
    end
    chk("r_hold", r, r_hold);

    // start held for 6 edges with changing c_in: edges 1 and 5 accepted
    for (int k = 0; k < 6; k++) vec[k] = (1142'b1 << (571 + 100 * k)) ^ 1142'(k * 37 + 5);
    pulses = 0;
    for (int k = 0; k < 12; k++) begin
      if (done) begin
        pulses++;
        seen.push_back(r);
      end
      if (k < 6) begin
        c_in  = vec[k];
        start = 1'b1;
      end else begin
        start = 1'b0;
      end
      @(negedge clk);
    end
    chk("held_pulses", 571'(pulses), 571'd2);
    while (seen.size() < 2) seen.push_back('x);
    chk("held_first", seen[0], ref_mod(vec[0]));
    chk("held_second", seen[1], ref_mod(vec[4]));

    // reset in FOLD1 aborts the operation
    c_v = rand_wide();
    c_in = c_v;
    start = 1'b1;
    @(negedge clk);
    start = 1'b0;
    rst = 1'b1;
    @(negedge clk);
    rst = 1'b0;
    chk("abort_busy", {570'b0, busy}, 571'd0);
    chk("abort_r", r, '0);
    pulses = 0;
    for (int k = 0; k < 5; k++) begin
      if (done) pulses++;
      @(negedge clk);
    end
    chk("abort_no_done", 571'(pulses), 571'd0);
    reduce(c_v, ref_mod(c_v), "after_abort");

    // back-to-back random and product inputs
    for (int k = 0; k < 1000; k++) begin
      if (k % 2 == 0) c_v = rand_wide();
      else begin
        c_v = rand_wide();
        c_v = clmul(c_v[570:0], c_v[1141:571]);
      end
      reduce(c_v, ref_mod(c_v), $sformatf("rand%0d", k));
    end

    $display("CHECKS %0d ERRORS %0d", checks, errors);
    $finish;
  end

endmodule
